// File: rtl/mem_word_loader.sv
// Byte-stream to 32-bit word loader for the PMU 256x32 word memory: packs bytes
// little-endian and writes consecutive words. MEM_WORD_LOADER_CKSUM_EN adds cksum_o.
module mem_word_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  num_words_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  word_cnt_o
`ifdef MEM_WORD_LOADER_CKSUM_EN
    ,
    output logic [31:0]       cksum_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       pack_q;
    logic              start_ok;
    logic              byte_take;
    logic [CNT_W-1:0]  num_clamped;

    assign start_ok    = (state_q == S_IDLE) && start_i && !abort_i;
    assign byte_take   = (state_q == S_COLLECT) && byte_valid_i;
    assign num_clamped = (num_words_i > MAX_WORDS) ? MAX_WORDS : num_words_i;

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok)
                    state_d = (num_words_i == '0) ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                if (abort_i)
                    state_d = S_IDLE;
                else if (byte_valid_i && byte_idx_q == 2'd3)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort_i)
                    state_d = S_IDLE;
                else if (remaining_q == CNT_W'(1))
                    state_d = S_DONE;
                else
                    state_d = S_COLLECT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // A write that coincides with abort still lands in memory, so the counters advance too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            pack_q      <= '0;
        end else if (start_ok) begin
            addr_q      <= base_addr_i;
            remaining_q <= num_clamped;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            pack_q      <= '0;
        end else if (byte_take) begin
            pack_q[{byte_idx_q, 3'b000} +: 8] <= byte_i;
            byte_idx_q                        <= byte_idx_q + 2'd1;
        end else if (state_q == S_WRITE) begin
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - CNT_W'(1);
            word_cnt_q  <= word_cnt_q + CNT_W'(1);
        end
    end

`ifdef MEM_WORD_LOADER_CKSUM_EN
    logic [31:0] cksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cksum_q <= '0;
        else if (start_ok)
            cksum_q <= '0;
        else if (state_q == S_WRITE)
            cksum_q <= {cksum_q[30:0], cksum_q[31]} ^ pack_q;
    end

    assign cksum_o = cksum_q;
`endif

    assign byte_ready_o = (state_q == S_COLLECT);
    assign mem_we_o     = (state_q == S_WRITE);
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = pack_q;
    assign busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign done_o       = (state_q == S_DONE);
    assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_mem_word_loader.sv
// Self-checking bench for mem_word_loader: directed scenarios plus random loads
// compared against a word-list reference model and a bench-side memory array.
module tb_mem_word_loader;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic [CNT_W-1:0]  num_words_i = '0;
    logic [7:0]        byte_i = '0;
    logic              byte_valid_i = 1'b0;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  word_cnt_o;
`ifdef MEM_WORD_LOADER_CKSUM_EN
    logic [31:0]       cksum_o;
`endif

    mem_word_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .base_addr_i  (base_addr_i),
        .num_words_i  (num_words_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .word_cnt_o   (word_cnt_o)
`ifdef MEM_WORD_LOADER_CKSUM_EN
        ,
        .cksum_o      (cksum_o)
`endif
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    wr_t         exp_q[$];
    logic [31:0] mem_model[256];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    bit          ready_seen = 1'b0;

    always #5 clk = ~clk;

    // Plays the role of the PMU memory and records every observed write and done pulse.
    always @(negedge clk) begin
        if (mem_we_o) begin
            wq.push_back(wr_t'{addr: mem_addr_o, data: mem_data_o});
            mem_model[mem_addr_o] = mem_data_o;
        end
        if (done_o) done_cnt++;
        if (byte_ready_o) ready_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] base, input logic [CNT_W-1:0] num);
        start_i     = 1'b1;
        base_addr_i = base;
        num_words_i = num;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            byte_valid_i = 1'b0;
            @(negedge clk);
        end
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (int k = 0; k < 50 && !byte_ready_o; k++) @(negedge clk);
        if (!byte_ready_o) check("ready_timeout", {31'b0, byte_ready_o}, 32'd1);
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done_o; k++) @(negedge clk);
        check("done_seen", {31'b0, done_o}, 32'd1);
    endtask

    task automatic run_load(input logic [7:0] base, input int num, input int min_gap,
                            input int max_gap, input bit seq);
        logic [7:0]  bytes[$];
        logic [31:0] w;
        logic [31:0] cs;
        int          eff;
        wq.delete();
        exp_q.delete();
        done_cnt = 0;
        eff = (num > 256) ? 256 : num;
        for (int i = 0; i < eff * 4; i++)
            bytes.push_back(seq ? 8'(i + 1) : 8'($urandom));
        cs = '0;
        for (int i = 0; i < eff; i++) begin
            w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            exp_q.push_back(wr_t'{addr: 8'(int'(base) + i), data: w});
            cs = {cs[30:0], cs[31]} ^ w;
        end
        do_start(base, CNT_W'(num));
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], $urandom_range(max_gap, min_gap));
            if (i % 4 == 3) begin
                check("we_latency", {31'b0, mem_we_o}, 32'd1);
                check("we_addr", {24'b0, mem_addr_o}, {24'b0, exp_q[i/4].addr});
            end
        end
        wait_done(200);
        @(negedge clk);
        #1;
        check("wr_count", wq.size(), eff);
        for (int i = 0; i < eff && i < wq.size(); i++) begin
            check("wr_addr", {24'b0, wq[i].addr}, {24'b0, exp_q[i].addr});
            check("wr_data", wq[i].data, exp_q[i].data);
        end
        check("done_pulses", done_cnt, 1);
        check("word_cnt", {23'b0, word_cnt_o}, eff);
        check("busy_after", {31'b0, busy_o}, 32'd0);
        check("addr_after", {24'b0, mem_addr_o}, {24'b0, 8'(int'(base) + eff)});
        if (eff > 0) check("data_after", mem_data_o, exp_q[eff-1].data);
`ifdef MEM_WORD_LOADER_CKSUM_EN
        check("cksum_model", cksum_o, cs);
`endif
    endtask

    initial begin
        logic [7:0]  b[4];
        logic [31:0] w1;

        // Reset values while rst_n is held low.
        #12;
        check("rst_ready", {31'b0, byte_ready_o}, 32'd0);
        check("rst_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_addr", {24'b0, mem_addr_o}, 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_cnt", {23'b0, word_cnt_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of COLLECT.
        wq.delete();
        do_start(8'h05, 9'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        check("mid_busy_pre", {31'b0, busy_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", {31'b0, busy_o}, 32'd0);
        check("async_ready", {31'b0, byte_ready_o}, 32'd0);
        check("async_addr", {24'b0, mem_addr_o}, 32'd0);
        check("async_data", mem_data_o, 32'd0);
        check("async_cnt", {23'b0, word_cnt_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("async_no_write", wq.size(), 0);
        check("async_idle", {31'b0, busy_o}, 32'd0);

        // Basic two-word load with back-to-back bytes 01..08.
        run_load(8'h10, 2, 0, 0, 1'b1);
        check("mem_rd_10", mem_model[8'h10], 32'h04030201);
        check("mem_rd_11", mem_model[8'h11], 32'h08070605);

        // Address wrap with valid dropped every other cycle.
        run_load(8'hFF, 2, 1, 1, 1'b0);
        check("wrap_addr0", wq.size() > 0 ? {24'b0, wq[0].addr} : 32'hDEAD, 32'h000000FF);
        check("wrap_addr1", wq.size() > 1 ? {24'b0, wq[1].addr} : 32'hDEAD, 32'h00000000);

        // Zero word count goes straight to DONE.
        wq.delete();
        done_cnt   = 0;
        ready_seen = 1'b0;
        do_start(8'h33, 9'd0);
        #1;
        check("zero_done", {31'b0, done_o}, 32'd1);
        @(negedge clk);
        #1;
        check("zero_done_end", {31'b0, done_o}, 32'd0);
        check("zero_no_write", wq.size(), 0);
        check("zero_cnt", {23'b0, word_cnt_o}, 32'd0);
        check("zero_ready", {31'b0, ready_seen}, 32'd0);
        check("zero_pulses", done_cnt, 1);

        // Abort partway through word 2, with an ignored start while busy.
        wq.delete();
        done_cnt = 0;
        do_start(8'h40, 9'd3);
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        w1 = {b[3], b[2], b[1], b[0]};
        send_byte(b[0], 0);
        do_start(8'hAA, 9'd9);
        for (int i = 1; i < 4; i++) send_byte(b[i], 0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_busy", {31'b0, busy_o}, 32'd0);
        check("abort_writes", wq.size(), 1);
        check("abort_w_addr", wq.size() > 0 ? {24'b0, wq[0].addr} : 32'hDEAD, 32'h00000040);
        check("abort_w_data", wq.size() > 0 ? wq[0].data : ~w1, w1);
        check("abort_no_done", done_cnt, 0);
        check("abort_cnt", {23'b0, word_cnt_o}, 32'd1);
        check("abort_addr", {24'b0, mem_addr_o}, 32'h00000041);

        // Abort during WRITE: the write still lands and is counted.
        wq.delete();
        done_cnt = 0;
        do_start(8'h80, 9'd2);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("abortw_writes", wq.size(), 1);
        check("abortw_cnt", {23'b0, word_cnt_o}, 32'd1);
        check("abortw_busy", {31'b0, busy_o}, 32'd0);
        check("abortw_addr", {24'b0, mem_addr_o}, 32'h00000081);
        check("abortw_no_done", done_cnt, 0);

        // start_i together with abort_i in IDLE is refused.
        done_cnt = 0;
        start_i  = 1'b1;
        abort_i  = 1'b1;
        base_addr_i = 8'h01;
        num_words_i = 9'd1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        #1;
        check("collide_busy", {31'b0, busy_o}, 32'd0);
        check("collide_done", {31'b0, done_o}, 32'd0);
        @(negedge clk);
        #1;
        check("collide_idle", {31'b0, busy_o}, 32'd0);
        check("collide_pulses", done_cnt, 0);

        // Random loads.
        for (int r = 0; r < 6; r++)
            run_load(8'($urandom), $urandom_range(6, 1), 0, 2, 1'b0);

        // Full fill from 0 and a clamped oversize count.
        run_load(8'h00, 256, 0, 0, 1'b0);
        run_load(8'h20, 300, 0, 0, 1'b0);

`ifdef MEM_WORD_LOADER_CKSUM_EN
        // Checksum: rotate-left-1 then XOR per written word.
        do_start(8'h00, 9'd2);
        send_byte(8'h01, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        @(negedge clk);
        #1;
        check("cksum_w1", cksum_o, 32'h00000001);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        send_byte(8'h80, 0);
        @(negedge clk);
        #1;
        check("cksum_w2", cksum_o, 32'h80000002);
        wait_done(20);
        @(negedge clk);
        #1;
        check("cksum_hold", cksum_o, 32'h80000002);
        do_start(8'h00, 9'd1);
        #1;
        check("cksum_clear", cksum_o, 32'h00000000);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        wait_done(20);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_word_loader.md
Name: mem_word_loader

Overview:
- Upstream fill stage for the PMU 256x32 word memory (clk, we, data_i[31:0], address[7:0], data_o[31:0]).
- Accepts a byte stream over a valid/ready handshake and packs every 4 bytes little-endian into a 32-bit word.
- Writes each word to consecutive memory addresses from a programmed base, for a programmed word count.
- Reports busy, completion and progress to the PMU control logic.

Parameters:
- ADDR_W, 8, memory address width; depth is 2^ADDR_W words.
- CNT_W, 9, word-count width; must hold 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle request to begin a load; ignored unless IDLE.
- abort_i  input  1  cancels a load in progress; higher priority than start_i.
- base_addr_i  input  ADDR_W  first word address; sampled on accepted start.
- num_words_i  input  CNT_W  words to load, 0..256; sampled on accepted start.
- byte_i  input  8  stream byte.
- byte_valid_i  input  1  byte_i valid.
- byte_ready_o  output  1  loader accepts byte this cycle.
- mem_we_o  output  1  to mem we.
- mem_addr_o  output  ADDR_W  to mem address.
- mem_data_o  output  32  to mem data_i.
- busy_o  output  1  high in COLLECT or WRITE.
- done_o  output  1  one-cycle completion pulse.
- word_cnt_o  output  CNT_W  words written since last accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs are 0: byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, word_cnt_o.
  - The internal byte index, remaining count and packing register are cleared.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - byte_ready_o=0.
  - If start_i=1 and abort_i=0, the start is accepted:
    - addr<=base_addr_i, remaining<=num_words_i, word_cnt_o<=0, byte_idx<=0, pack<=0.
    - If num_words_i==0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - byte_ready_o=1.
  - On byte_valid_i&byte_ready_o, byte_i is stored in lane byte_idx: the first byte goes to [7:0] and the fourth to [31:24]. byte_idx then increments.
  - Acceptance of the 4th byte moves the FSM to WRITE.
  - Stalls (valid low) are held indefinitely with no timeout.
- WRITE (exactly one cycle):
  - mem_we_o=1, mem_data_o=packed word, mem_addr_o=addr, byte_ready_o=0.
  - Next cycle: addr<=addr+1, modulo 2^ADDR_W (255 wraps to 0). remaining<=remaining-1. word_cnt_o<=word_cnt_o+1.
  - If remaining==1, go to DONE; else go to COLLECT with byte_idx=0.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Latency:
  - The 4th byte is accepted on edge N; mem_we_o is high during cycle N+1.
  - Peak throughput is one word per 5 cycles.
- mem_addr_o is always driven with the current addr, so mem data_o reflects that word combinationally.
  - After completion, mem_addr_o holds last_written+1.
  - mem_data_o holds the last packed word.
- mem_we_o is never high outside WRITE.
- abort_i in COLLECT or WRITE:
  - Next state is IDLE and the partial word is discarded.
  - If abort_i arrives in WRITE, the write in that cycle still occurs, because mem samples we on the same edge. word_cnt_o still increments.
  - done_o is not pulsed.
- abort_i in IDLE or DONE: no effect, except that it blocks start_i in IDLE.
- start_i while busy is ignored and does not alter addr or count.
- num_words_i=256 with base 0 fills the whole memory and addr wraps back to 0.
- Values of num_words_i above 256 are clamped to 256.

Optional Feature:
MEM_WORD_LOADER_CKSUM_EN
- Defined:
  - Adds output port cksum_o[31:0], reset to 0 and cleared on an accepted start.
  - On each WRITE cycle, cksum_o <= {cksum_o[30:0],cksum_o[31]} ^ mem_data_o (rotate-left-1, then XOR), updated on the same edge as word_cnt_o.
  - cksum_o is held after done_o for the PMU to compare against the bitstream trailer.
- Undefined: the cksum_o port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset mid-COLLECT: 2 bytes in, rst_n low -> all outputs 0 immediately (asynchronous). After release, no write has occurred and the FSM is in IDLE.
- Basic load: base=0x10, num=2, bytes 01 02 03 04 05 06 07 08 sent back-to-back ->
  - we at 0x10 with 0x04030201, then we at 0x11 with 0x08070605;
  - done_o pulses once and word_cnt_o=2;
  - mem readback at 0x10/0x11 matches.
- Wrap and throttle: base=0xFF, num=2, byte_valid_i toggled every other cycle -> writes at 0xFF then 0x00, and exactly 2 we pulses.
- Zero count: num=0 -> done_o the cycle after IDLE, no we, word_cnt_o=0, byte_ready_o never high.
- Abort and start collisions:
  - abort after 3 bytes of word 2 (num=3) -> only word 1 written, no done_o, IDLE.
  - start_i during busy is ignored.
  - start_i+abort_i together in IDLE -> stays IDLE.
- CKSUM_EN build: words 0x00000001 then 0x80000000 -> cksum_o=0x00000001 after the first word and 0x80000002 after the second. cksum_o is cleared on the next start.
